// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stall, multi-cycle MULT/DIV freeze,
// IF/ID flush on taken branch, plus a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int MD_CYCLES = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic             memread_ex,
  input  logic [4:0]       rd_ex,
  input  logic             md_start,
  input  logic             branch_taken,
  output logic             pc_ena,
  output logic             if_id_ena,
  output logic             if_id_flush,
  output logic             id_ex_ena,
  output logic             id_ex_bubble,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MD_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;

  typedef enum logic {RUN, MD_WAIT} state_t;

  state_t          state, state_nxt;
  logic [MD_W-1:0] md_cnt, md_cnt_nxt;
  logic            lu;

  // r0 is hard-wired zero, so a load targeting it never creates a hazard
  assign lu = memread_ex && (rd_ex != 5'd0) &&
              ((use_rs_id && (rs_id == rd_ex)) || (use_rt_id && (rt_id == rd_ex)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    case (state)
      RUN: begin
        if (md_start) begin
          state_nxt  = MD_WAIT;
          md_cnt_nxt = MD_W'(MD_CYCLES - 2);
        end
      end
      MD_WAIT: begin
        if (md_cnt == '0) state_nxt = RUN;
        else              md_cnt_nxt = md_cnt - 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_ena       = 1'b1;
    if_id_ena    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_ena    = 1'b1;
    id_ex_bubble = 1'b0;
    md_busy      = 1'b0;
    if (rst) begin
      pc_ena       = 1'b0;
      if_id_ena    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (md_start) begin
            pc_ena    = 1'b0;
            if_id_ena = 1'b0;
            id_ex_ena = 1'b0;
            md_busy   = 1'b1;
          end else if (lu) begin
            // branch operands not yet valid: stall instead of flushing
            pc_ena       = 1'b0;
            if_id_ena    = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (branch_taken) begin
            if_id_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          pc_ena    = 1'b0;
          if_id_ena = 1'b0;
          id_ex_ena = 1'b0;
          md_busy   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                           stall_cnt <= '0;
    else if (!pc_ena && ~&stall_cnt)   stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: driver pushes model-predicted outputs, monitor pops and compares.
module tb_hazard_stall_ctrl;
  localparam int MD_CYCLES = 8;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, use_rs_id, use_rt_id, memread_ex, md_start, branch_taken;
  logic [4:0] rs_id, rt_id, rd_ex;
  logic pc_ena, if_id_ena, if_id_flush, id_ex_ena, id_ex_bubble, md_busy;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MD_CYCLES(MD_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .memread_ex(memread_ex),
    .rd_ex(rd_ex), .md_start(md_start), .branch_taken(branch_taken),
    .pc_ena(pc_ena), .if_id_ena(if_id_ena), .if_id_flush(if_id_flush),
    .id_ex_ena(id_ex_ena), .id_ex_bubble(id_ex_bubble), .md_busy(md_busy),
    .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic pc, ifid, flush, idex, bubble, busy;
  } ctl_t;

  typedef struct {
    string tag;
    ctl_t  ctl;
    int    cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, errors = 0;
  int cyc = 0;
  bit done = 0;

  // reference model: remaining MULT/DIV stall cycles and stall count
  int m_md_rem = 0;
  int m_cnt = 0;

  task automatic step(input string tag, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic mr, input logic [4:0] rd,
                      input logic mds, input logic br);
    exp_t e;
    bit hz;
    @(negedge clk);
    rst = r; rs_id = rs; rt_id = rt; use_rs_id = urs; use_rt_id = urt;
    memread_ex = mr; rd_ex = rd; md_start = mds; branch_taken = br;
    hz = mr && rd != 0 && ((urs && rs == rd) || (urt && rt == rd));
    e.tag = tag;
    e.cnt = m_cnt;
    if (r) begin
      e.ctl = '{pc:0, ifid:0, flush:1, idex:1, bubble:1, busy:0};
      m_md_rem = 0;
      m_cnt = 0;
    end else begin
      if (m_md_rem > 0) begin
        e.ctl = '{pc:0, ifid:0, flush:0, idex:0, bubble:0, busy:1};
        m_md_rem--;
      end else if (mds) begin
        e.ctl = '{pc:0, ifid:0, flush:0, idex:0, bubble:0, busy:1};
        m_md_rem = MD_CYCLES - 1;
      end else if (hz)
        e.ctl = '{pc:0, ifid:0, flush:0, idex:1, bubble:1, busy:0};
      else if (br)
        e.ctl = '{pc:1, ifid:1, flush:1, idex:1, bubble:0, busy:0};
      else
        e.ctl = '{pc:1, ifid:1, flush:0, idex:1, bubble:0, busy:0};
      if (!e.ctl.pc && m_cnt < CNT_MAX) m_cnt++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 0);
  endtask

  // monitor: outputs are combinational, so every cycle presents a response
  initial begin
    exp_t e;
    ctl_t got;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = '{pc_ena, if_id_ena, if_id_flush, id_ex_ena, id_ex_bubble, md_busy};
        checks++;
        if (got !== e.ctl) begin
          errors++;
          $display("FAIL %s ctl cyc=%0d got=%b exp=%b (pc,ifid,flush,idex,bub,busy)",
                   e.tag, cyc, got, e.ctl);
        end
        checks++;
        if (stall_cnt !== CNT_W'(e.cnt)) begin
          errors++;
          $display("FAIL %s stall_cnt cyc=%0d got=%0d exp=%0d", e.tag, cyc, stall_cnt, e.cnt);
        end
      end
      cyc++;
    end
  end

  initial begin
    rst = 1; rs_id = 0; rt_id = 0; use_rs_id = 0; use_rt_id = 0;
    memread_ex = 0; rd_ex = 0; md_start = 0; branch_taken = 0;
    m_cnt = 0;
    // reset for three cycles; counter starts at zero
    repeat (3) step("reset", 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
    idle("idle");
    // load-use on rs, then the same with rd=0
    step("lu_rs", 0, 5'd5, 5'd7, 1, 0, 1, 5'd5, 0, 0);
    idle("after_lu");
    step("lu_r0", 0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0);
    step("lu_rt", 0, 5'd3, 5'd9, 0, 1, 1, 5'd9, 0, 0);
    step("lu_unused", 0, 5'd9, 5'd4, 0, 1, 1, 5'd9, 0, 0);
    // MULT/DIV with hazards and branches asserted during the wait
    step("md_start", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0);
    for (int i = 0; i < MD_CYCLES - 1; i++)
      step("md_wait", 0, 5'd6, 5'd6, 1, 1, 1, 5'd6, i[0], 1);
    idle("md_done");
    step("md_vs_lu", 0, 5'd6, 5'd6, 1, 1, 1, 5'd6, 1, 1);
    repeat (MD_CYCLES - 1) idle("md2_wait");
    // branch alone, then branch with load-use
    step("branch", 0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 1);
    step("branch_lu", 0, 5'd8, 5'd2, 1, 1, 1, 5'd8, 0, 1);
    // reset in the 4th MD_WAIT cycle
    step("md_start2", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0);
    repeat (3) idle("md_wait2");
    step("rst_in_md", 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
    idle("post_rst");
    step("post_rst_br", 0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 1);
    // hold load-use long enough to saturate the counter
    repeat (20) step("saturate", 0, 5'd12, 5'd0, 1, 0, 1, 5'd12, 0, 0);
    idle("sat_hold");
    // randomized traffic, biased toward register collisions
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] rd;
      rd = 5'($urandom_range(0, 3));
      step("random", ($urandom_range(0, 99) < 2), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), ($urandom_range(0, 99) < 40), rd,
           ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 20));
    end
    idle("tail");
    @(negedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
